pipe_stage_reg: RTL

Generic, parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It replaces the fixed-field stall/flush stage registers between core pipeline stages. Payload is split into data fields, which are held, and control fields, which are forced to zero whenever no valid beat is present, so a bubble never asserts write enables. Built-in saturating counters report downstream stall and bubble cycles for performance analysis.

---
 rtl/pipe_stage_reg.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Parametrised pipeline stage register with valid/ready handshake
//             and a 2-entry skid buffer (main + skid). Control fields are
//             zeroed on flush and masked when no beat is present, so a bubble
//             never asserts a downstream write enable. Data fields are held.
//             Saturating counters report downstream stall and bubble cycles.
//  Ports    :
//    clk, rst           clock / asynchronous active-high reset
//    flush              synchronous kill of all held beats (beats only)
//    stat_clr           synchronous clear of both counters
//    in_valid/in_ready  upstream handshake (in_ready is registered)
//    in_data/in_ctrl    upstream payload
//    out_valid/out_ready downstream handshake
//    out_data/out_ctrl  downstream payload (out_ctrl = 0 when !out_valid)
//    occupancy          beats held: 0, 1 or 2
//    stall_cycles       cycles with out_valid=1, out_ready=0 (saturating)
//    bubble_cycles      cycles with out_valid=0, out_ready=1 (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stat_clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  bubble_cycles
);

   // Encoding mirrors {main_valid, skid_valid}.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   state_t              state_q,     state_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic                in_ready_q,  in_ready_d;
   logic [1:0]          occupancy_q, occupancy_d;
   logic [CNT_W-1:0]    stall_q,     stall_d;
   logic [CNT_W-1:0]    bubble_q,    bubble_d;

   logic w_main_valid;
   logic w_accept;
   logic w_deliver;

   assign w_main_valid = (state_q != ST_EMPTY);
   // in_ready_q is a registered copy of !skid_valid, so accept never depends
   // combinationally on out_ready.
   assign w_accept     = in_valid & in_ready_q;
   assign w_deliver    = w_main_valid & out_ready;

   // ------------------------------------------------------------------------
   // Next-state logic for the beat storage
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;

      if (flush) begin
         // Flush beats any handshake; data is kept, control is scrubbed.
         state_d     = ST_EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         case (state_q)
            ST_ONE: begin
               if (w_accept && w_deliver) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (w_accept) begin
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
                  state_d     = ST_FULL;
               end else if (w_deliver) begin
                  state_d     = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a delivery can happen.
               if (w_deliver) begin
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  state_d     = ST_ONE;
               end
            end
            default: begin
               if (w_accept) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
                  state_d     = ST_ONE;
               end
            end
         endcase
      end

      in_ready_d = (state_d != ST_FULL);
      case (state_d)
         ST_ONE:  occupancy_d = 2'd1;
         ST_FULL: occupancy_d = 2'd2;
         default: occupancy_d = 2'd0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Performance counters (independent of flush)
   // ------------------------------------------------------------------------
   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (stat_clr) begin
         stall_d  = '0;
         bubble_d = '0;
      end else begin
         if (w_main_valid && !out_ready && (stall_q != C_CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
         end
         if (!w_main_valid && out_ready && (bubble_q != C_CNT_MAX)) begin
            bubble_d = bubble_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b1;
         occupancy_q <= 2'd0;
         stall_q     <= '0;
         bubble_q    <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= in_ready_d;
         occupancy_q <= occupancy_d;
         stall_q     <= stall_d;
         bubble_q    <= bubble_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign in_ready      = in_ready_q;
   assign out_valid     = w_main_valid;
   assign out_data      = main_data_q;
   assign out_ctrl      = w_main_valid ? main_ctrl_q : '0;
   assign occupancy     = occupancy_q;
   assign stall_cycles  = stall_q;
   assign bubble_cycles = bubble_q;

endmodule
`default_nettype wire
